// File: rtl/spy_fifo_rr_merger_if.sv
// Bus between the input spy-FIFO bank, the round-robin merger and the DUT-side FIFO.
// The slave modport is the merger's view of the bus; master is the environment's view.
interface spy_fifo_rr_merger_if #(
    parameter int N_INPUTS   = 4,
    parameter int DATA_WIDTH = 256,
    parameter int SRC_BITS   = 2
);
    logic [N_INPUTS*DATA_WIDTH-1:0] in_data;
    logic [N_INPUTS-1:0]            in_empty;
    logic [N_INPUTS-1:0]            in_read_enable;
    logic [DATA_WIDTH-1:0]          out_data;
    logic [SRC_BITS-1:0]            out_src;
    logic                           out_write_enable;
    logic                           out_almost_full;
    logic                           busy;
    logic                           timeout_err;

    modport slave (
        input  in_data, in_empty, out_almost_full,
        output in_read_enable, out_data, out_src, out_write_enable, busy, timeout_err
    );

    modport master (
        output in_data, in_empty, out_almost_full,
        input  in_read_enable, out_data, out_src, out_write_enable, busy, timeout_err
    );
endinterface

// File: rtl/spy_fifo_rr_merger.sv
// Packet-aware round-robin merger: drains N input FWFT FIFOs into one sink FIFO,
// holding each grant until EOP, tagging words with their source, and guarding stalls.
module spy_fifo_rr_merger #(
    parameter int N_INPUTS   = 4,
    parameter int DATA_WIDTH = 256,
    parameter int SRC_BITS   = 2,
    parameter int TIMEOUT    = 255
) (
    input logic                clock,
    input logic                reset,
    spy_fifo_rr_merger_if.slave bus
);
    typedef enum logic {IDLE, LOCKED} state_t;

    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

    state_t                state_q;
    logic [SRC_BITS-1:0]   grant_q, ptr_q, ptr_d, pick;
    logic [15:0]           wdog_q;
    logic [DATA_WIDTH-1:0] out_data_q, sel_data;
    logic [SRC_BITS-1:0]   out_src_q;
    logic                  out_we_q, busy_q, tmo_q;
    logic                  found, sel_empty, xfer, eop;

    // Mux of the granted input; one-hot compare keeps indices constant.
    always_comb begin
        sel_data  = '0;
        sel_empty = 1'b1;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (grant_q == SRC_BITS'(i)) begin
                sel_data  = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_empty = bus.in_empty[i];
            end
        end
    end

    // First non-empty input at or after ptr_q; lower offsets k are applied last and win.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        for (int k = N_INPUTS - 1; k >= 0; k--) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                if (!bus.in_empty[i] &&
                    ((int'(ptr_q) + k == i) || (int'(ptr_q) + k == i + N_INPUTS))) begin
                    found = 1'b1;
                    pick  = SRC_BITS'(i);
                end
            end
        end
    end

    assign xfer  = (state_q == LOCKED) && !sel_empty && !bus.out_almost_full;
    assign eop   = sel_data[DATA_WIDTH-1];
    assign ptr_d = (int'(grant_q) == N_INPUTS - 1) ? '0 : grant_q + 1'b1;

    always_comb begin
        bus.in_read_enable = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (!reset && xfer && grant_q == SRC_BITS'(i)) bus.in_read_enable[i] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            wdog_q     <= '0;
            out_data_q <= '0;
            out_src_q  <= '0;
            out_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            out_we_q <= xfer;
            tmo_q    <= 1'b0;
            if (xfer) begin
                out_data_q <= sel_data;
                out_src_q  <= grant_q;
            end
            case (state_q)
                IDLE: begin
                    wdog_q <= '0;
                    if (found) begin
                        grant_q <= pick;
                        state_q <= LOCKED;
                        busy_q  <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (xfer) begin
                        wdog_q <= '0;
                        if (eop) begin
                            state_q <= IDLE;
                            ptr_q   <= ptr_d;
                            busy_q  <= 1'b0;
                        end
                    end else if (sel_empty) begin
                        // Sink back-pressure alone never advances the watchdog.
                        if (wdog_q == WDOG_LAST) begin
                            tmo_q   <= 1'b1;
                            state_q <= IDLE;
                            ptr_q   <= ptr_d;
                            busy_q  <= 1'b0;
                            wdog_q  <= '0;
                        end else begin
                            wdog_q <= wdog_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.out_data         = out_data_q;
    assign bus.out_src          = out_src_q;
    assign bus.out_write_enable = out_we_q;
    assign bus.busy             = busy_q;
    assign bus.timeout_err      = tmo_q;
endmodule

// File: tb/tb_spy_fifo_rr_merger.sv
// Bench for spy_fifo_rr_merger: FWFT input FIFO models, scoreboard on the write strobe,
// and directed cycle checks for arbitration, back-pressure, watchdog and reset.
module tb_spy_fifo_rr_merger;
    localparam int N  = 4;
    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [1:0]    s;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    spy_fifo_rr_merger_if #(.N_INPUTS(N), .DATA_WIDTH(DW), .SRC_BITS(2)) bus ();

    spy_fifo_rr_merger #(.N_INPUTS(N), .DATA_WIDTH(DW), .SRC_BITS(2), .TIMEOUT(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          tmo_cnt = 0;
    exp_t        exp_q[$];
    int          wr_cyc[$];
    exp_t        e;
    logic [DW-1:0] fmem [N][32];
    int unsigned hd [N] = '{0, 0, 0, 0};
    int unsigned tl [N] = '{0, 0, 0, 0};

    function automatic void chk(string name, logic [31:0] got, logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, expv, $time);
        end
    endfunction

    // Input FIFO models: first-word-fall-through views of per-input circular buffers
    always_comb begin
        bus.in_data  = '0;
        bus.in_empty = '1;
        for (int i = 0; i < N; i++) begin
            bus.in_empty[i]          = (hd[i] == tl[i]);
            bus.in_data[i*DW +: DW]  = fmem[i][hd[i] % 32];
        end
    end

    always @(posedge clock) begin
        cyc <= cyc + 1;
        for (int i = 0; i < N; i++) begin
            if (bus.in_read_enable[i]) begin
                chk("pop_nonempty", 32'(bus.in_empty[i]), 0);
                hd[i] <= hd[i] + 1;
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clock) begin
        if (bus.timeout_err) tmo_cnt++;
        if (bus.out_write_enable) begin
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got data %0h src %0d expected no write",
                         bus.out_data, bus.out_src);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", 32'(bus.out_data), 32'(e.d));
                chk("sb_src", 32'(bus.out_src), 32'(e.s));
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic expect_word(logic [DW-1:0] d, int s);
        exp_t x;
        x.d = d;
        x.s = 2'(s);
        exp_q.push_back(x);
    endtask

    task automatic push(int i, logic [DW-1:0] d, bit expected);
        fmem[i][tl[i] % 32] = d;
        tl[i] = tl[i] + 1;
        if (expected) expect_word(d, i);
    endtask

    task automatic drain(string name);
        int t = 0;
        do begin
            tick();
            t++;
        end while (!(exp_q.size() == 0 && !bus.busy && !bus.out_write_enable &&
                     bus.in_empty == '1) && t < 300);
        chk(name, 32'(exp_q.size()), 0);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [4:0] eb, ew;
        int         wcnt, t;

        reset = 1'b1;
        bus.out_almost_full = 1'b0;
        repeat (2) tick();
        chk("rst_we", 32'(bus.out_write_enable), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_tmo", 32'(bus.timeout_err), 0);
        chk("rst_data", 32'(bus.out_data), 0);
        chk("rst_src", 32'(bus.out_src), 0);
        chk("rst_rd", 32'(bus.in_read_enable), 0);
        reset = 1'b0;
        tick();

        // 3-word packet on input 0: bubble, three pops, writes lag pops by one
        push(0, 16'h0001, 1);
        push(0, 16'h0002, 1);
        push(0, 16'h8003, 1);
        #1;
        chk("t1_idle_busy", 32'(bus.busy), 0);
        chk("t1_idle_rd", 32'(bus.in_read_enable), 0);
        eb = 5'b00111;
        ew = 5'b01110;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t1_busy", 32'(bus.busy), 32'(eb[c]));
            chk("t1_rd", 32'(bus.in_read_enable), eb[c] ? 1 : 0);
            chk("t1_we", 32'(bus.out_write_enable), 32'(ew[c]));
        end
        drain("t1_drain");

        // Two 2-word packets per input: round-robin order with one idle cycle per packet
        do_reset();
        wr_cyc.delete();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < N; i++) begin
                push(i, 16'((i << 8) | (p << 4)), 1);
                push(i, 16'(16'h8000 | (i << 8) | (p << 4) | 1), 1);
            end
        end
        drain("t2_drain");
        chk("t2_nwr", 32'(wr_cyc.size()), 16);
        if (wr_cyc.size() == 16) begin
            for (int k = 1; k < 16; k++)
                chk("t2_gap", 32'(wr_cyc[k] - wr_cyc[k-1]), (k % 2 == 1) ? 1 : 2);
        end

        // Back-pressure held longer than the watchdog limit, mid-packet
        push(0, 16'h0031, 1);
        push(0, 16'h0032, 1);
        push(0, 16'h0033, 1);
        push(0, 16'h0034, 1);
        push(0, 16'h0035, 1);
        push(0, 16'h8036, 1);
        repeat (3) tick();
        bus.out_almost_full = 1'b1;
        #1;
        chk("t3_af_rd_now", 32'(bus.in_read_enable), 0);
        wcnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("t3_af_rd", 32'(bus.in_read_enable), 0);
            chk("t3_af_busy", 32'(bus.busy), 1);
            if (bus.out_write_enable) wcnt++;
        end
        chk("t3_af_writes_le1", 32'(wcnt <= 1), 1);
        bus.out_almost_full = 1'b0;
        drain("t3_drain");
        chk("t3_no_tmo", 32'(tmo_cnt), 0);

        // Watchdog: input 2 goes dry after its first word, input 3 is next in line
        push(2, 16'h0201, 1);
        push(3, 16'h8301, 1);
        t = 0;
        while (!bus.out_write_enable && t < 10) begin
            tick();
            t++;
        end
        chk("t4_first_wr", 32'(bus.out_write_enable), 1);
        for (int c = 1; c <= 9; c++) begin
            tick();
            chk("t4_tmo", 32'(bus.timeout_err), (c == 8) ? 1 : 0);
            if (c == 8) chk("t4_busy_drop", 32'(bus.busy), 0);
        end
        drain("t4_drain");
        chk("t4_tmo_count", 32'(tmo_cnt), 1);

        // Reset mid-packet on input 1 with ptr moved to 2 beforehand
        push(1, 16'h8100, 1);
        drain("t5_pre_drain");
        push(1, 16'h0101, 1);
        push(1, 16'h0102, 1);
        push(1, 16'h0103, 0);
        push(1, 16'h8104, 0);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        chk("t5_rst_rd", 32'(bus.in_read_enable), 0);
        tick();
        reset = 1'b0;
        chk("t5_we", 32'(bus.out_write_enable), 0);
        chk("t5_busy", 32'(bus.busy), 0);
        chk("t5_tmo", 32'(bus.timeout_err), 0);
        chk("t5_data", 32'(bus.out_data), 0);
        chk("t5_src", 32'(bus.out_src), 0);
        // ptr back at 0 selects leftover input 1 ahead of input 3
        expect_word(16'h0103, 1);
        expect_word(16'h8104, 1);
        push(3, 16'h8301, 1);
        drain("t5_drain");

        // Wrap-around from ptr=3 with single-word packets
        push(2, 16'h8201, 1);
        drain("t6_pre_drain");
        wr_cyc.delete();
        push(3, 16'h8302, 1);
        push(0, 16'h8002, 1);
        drain("t6_drain");
        chk("t6_nwr", 32'(wr_cyc.size()), 2);
        if (wr_cyc.size() == 2) chk("t6_gap", 32'(wr_cyc[1] - wr_cyc[0]), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "global timeout");
    end
endmodule
